aoi_filt: RTL and testbench

- Parametrised, registered successor to the single ao211 cell: WIDTH independent AND-OR-INVERT channels.
- Each channel computes Y = ~((AND of AND_N inputs) | (OR of OR_N inputs)).
- Each result is registered, then passed through a per-channel stability filter (deglitcher). An output changes only after its raw result has differed from it for STABLE consecutive enabled cycles.
- Used where AOI-derived control terms must be clean, synchronous and free of single-cycle glitches.

---
 rtl/aoi_filt.sv | 90 +++++++++
 tb/tb_aoi_filt.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aoi_filt.sv
// aoi_filt: WIDTH registered AND-OR-INVERT channels,
// each followed by a STABLE-cycle deglitch filter.
module aoi_filt #(
  parameter int WIDTH  = 4,
  parameter int AND_N  = 2,
  parameter int OR_N   = 2,
  parameter int STABLE = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [WIDTH*AND_N-1:0] and_in,
  input  logic [WIDTH*OR_N-1:0]  or_in,
  output logic [WIDTH-1:0]       y,
  output logic [WIDTH-1:0]       changed,
  output logic                   settled
);

  localparam int CW = $clog2(STABLE) + 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] y_nxt;
  logic [WIDTH-1:0] chg_nxt;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic             set_nxt;

  // raw AOI value for every channel
  always_comb begin
    raw = '0;
    for (int i = 0; i < WIDTH; i++) begin
      raw[i] = ~((&and_in[i*AND_N +: AND_N]) |
                 (|or_in[i*OR_N +: OR_N]));
    end
  end

  // filter next state: count disagreement, flip on the last count
  always_comb begin
    y_nxt   = y;
    chg_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (s1[i] == y[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == LAST) begin
        y_nxt[i]   = s1[i];
        cnt_nxt[i] = '0;
        chg_nxt[i] = 1'b1;
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  // settled reflects the state the registers will hold after the edge
  always_comb begin
    set_nxt = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (raw[i] != y_nxt[i] || cnt_nxt[i] != '0) begin
        set_nxt = 1'b0;
      end
    end
  end

  // state registers; en low freezes everything but changed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= '1;
      y       <= '1;
      changed <= '0;
      settled <= 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else if (en) begin
      s1      <= raw;
      y       <= y_nxt;
      changed <= chg_nxt;
      settled <= set_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end else begin
      changed <= '0;
    end
  end

endmodule

// File: tb/tb_aoi_filt.sv
// tb_aoi_filt: table vectors, hand sequences and random
// stimulus against a run-length reference model.
module tb_aoi_filt;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] and_a, or_a;
  logic [3:0] y_a, ch_a;
  logic       set_a;
  logic [5:0] and_b;
  logic [1:0] or_b;
  logic [1:0] y_b, ch_b;
  logic       set_b;

  int total = 0;
  int bad   = 0;

  aoi_filt #(.WIDTH(4), .AND_N(2), .OR_N(2), .STABLE(3)) dut_a (
    .clk(clk), .rst(rst), .en(en),
    .and_in(and_a), .or_in(or_a),
    .y(y_a), .changed(ch_a), .settled(set_a)
  );

  aoi_filt #(.WIDTH(2), .AND_N(3), .OR_N(1), .STABLE(1)) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .and_in(and_b), .or_in(or_b),
    .y(y_b), .changed(ch_b), .settled(set_b)
  );

  always #5 clk = ~clk;

  // reference model: sample, run length of disagreement, output
  int ma_s1[4], ma_run[4], ma_y[4], ma_ch[4], ma_set;
  int mb_s1[2], mb_run[2], mb_y[2], mb_ch[2], mb_set;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ma_s1[i] = 1; ma_run[i] = 0; ma_y[i] = 1; ma_ch[i] = 0;
    end
    for (int i = 0; i < 2; i++) begin
      mb_s1[i] = 1; mb_run[i] = 0; mb_y[i] = 1; mb_ch[i] = 0;
    end
    ma_set = 1;
    mb_set = 1;
  endtask

  // output of a filter: flips once the sampled value has
  // disagreed for stab consecutive enabled edges
  task automatic filt(input int stab, input int s, inout int y,
                      inout int run, output int ch);
    ch = 0;
    if (s == y) begin
      run = 0;
    end else if (run + 1 >= stab) begin
      y = s; run = 0; ch = 1;
    end else begin
      run = run + 1;
    end
  endtask

  task automatic check_all();
    logic [3:0] ey_a, ec_a;
    logic [1:0] ey_b, ec_b;
    for (int i = 0; i < 4; i++) begin
      ey_a[i] = ma_y[i][0]; ec_a[i] = ma_ch[i][0];
    end
    for (int i = 0; i < 2; i++) begin
      ey_b[i] = mb_y[i][0]; ec_b[i] = mb_ch[i][0];
    end
    chk("y_a", 32'(y_a), 32'(ey_a));
    chk("chg_a", 32'(ch_a), 32'(ec_a));
    chk("set_a", 32'(set_a), 32'(ma_set));
    chk("y_b", 32'(y_b), 32'(ey_b));
    chk("chg_b", 32'(ch_b), 32'(ec_b));
    chk("set_b", 32'(set_b), 32'(mb_set));
  endtask

  task automatic tick();
    int ra[4], rb[2];
    for (int i = 0; i < 4; i++)
      ra[i] = !((and_a[2*i +: 2] == 2'b11) || (or_a[2*i +: 2] != 0));
    for (int i = 0; i < 2; i++)
      rb[i] = !((and_b[3*i +: 3] == 3'b111) || (or_b[i] != 0));
    @(posedge clk);
    if (!rst && en) begin
      ma_set = 1;
      for (int i = 0; i < 4; i++) begin
        filt(3, ma_s1[i], ma_y[i], ma_run[i], ma_ch[i]);
        ma_s1[i] = ra[i];
        if (ma_s1[i] != ma_y[i] || ma_run[i] != 0) ma_set = 0;
      end
      mb_set = 1;
      for (int i = 0; i < 2; i++) begin
        filt(1, mb_s1[i], mb_y[i], mb_run[i], mb_ch[i]);
        mb_s1[i] = rb[i];
        if (mb_s1[i] != mb_y[i] || mb_run[i] != 0) mb_set = 0;
      end
    end else if (!rst) begin
      for (int i = 0; i < 4; i++) ma_ch[i] = 0;
      for (int i = 0; i < 2; i++) mb_ch[i] = 0;
    end
    #2;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  typedef struct {
    logic [1:0] a;
    logic [1:0] o;
    logic       y;
  } vec_t;

  vec_t tv[10];
  logic prev;

  initial begin
    tv[0] = '{2'b11, 2'b00, 1'b0};
    tv[1] = '{2'b00, 2'b00, 1'b1};
    tv[2] = '{2'b00, 2'b01, 1'b0};
    tv[3] = '{2'b00, 2'b00, 1'b1};
    tv[4] = '{2'b00, 2'b10, 1'b0};
    tv[5] = '{2'b00, 2'b00, 1'b1};
    tv[6] = '{2'b01, 2'b00, 1'b1};
    tv[7] = '{2'b10, 2'b00, 1'b1};
    tv[8] = '{2'b11, 2'b11, 1'b0};
    tv[9] = '{2'b00, 2'b00, 1'b1};

    rst = 1'b1; en = 1'b1;
    and_a = '0; or_a = '0; and_b = '0; or_b = '0;
    model_reset();
    #12 rst = 1'b0;
    chk("rst_y", 32'(y_a), 32'hf);
    chk("rst_chg", 32'(ch_a), 32'h0);
    chk("rst_set", 32'(set_a), 32'h1);
    ticks(2);

    // truth table on channel 0
    prev = 1'b1;
    for (int v = 0; v < 10; v++) begin
      and_a[1:0] = tv[v].a;
      or_a[1:0]  = tv[v].o;
      ticks(3);
      chk("tv_hold", 32'(y_a[0]), 32'(prev));
      chk("tv_cnt_set", 32'(set_a), 32'(tv[v].y == prev));
      tick();
      chk("tv_y", 32'(y_a[0]), 32'(tv[v].y));
      chk("tv_chg", 32'(ch_a[0]), 32'(tv[v].y != prev));
      tick();
      chk("tv_chg_end", 32'(ch_a[0]), 32'h0);
      chk("tv_set", 32'(set_a), 32'h1);
      prev = tv[v].y;
    end

    // 2-cycle glitch is rejected
    or_a[0] = 1'b1;
    ticks(2);
    or_a[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("gl2_y", 32'(y_a[0]), 32'h1);
      chk("gl2_chg", 32'(ch_a[0]), 32'h0);
    end
    chk("gl2_set", 32'(set_a), 32'h1);

    // 3-cycle pulse passes and returns
    or_a[0] = 1'b1;
    ticks(3);
    or_a[0] = 1'b0;
    tick();
    chk("gl3_y0", 32'(y_a[0]), 32'h0);
    chk("gl3_c0", 32'(ch_a[0]), 32'h1);
    ticks(3);
    chk("gl3_y1", 32'(y_a[0]), 32'h1);
    chk("gl3_c1", 32'(ch_a[0]), 32'h1);
    ticks(2);

    // enable freeze mid-count
    or_a[0] = 1'b1;
    ticks(2);
    en = 1'b0;
    ticks(5);
    chk("frz_y", 32'(y_a[0]), 32'h1);
    en = 1'b1;
    tick();
    chk("frz_y1", 32'(y_a[0]), 32'h1);
    tick();
    chk("frz_flip", 32'(y_a[0]), 32'h0);
    or_a[0] = 1'b0;
    ticks(6);

    // two channels flip together
    and_a = 8'b0011_0011;
    ticks(4);
    chk("mc_y", 32'(y_a), 32'hA);
    chk("mc_chg", 32'(ch_a), 32'h5);
    and_a = '0;
    ticks(6);

    // async reset while channel 0 has counted to 2
    or_a[1] = 1'b1;
    ticks(3);
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("ar_y", 32'(y_a), 32'hf);
    chk("ar_chg", 32'(ch_a), 32'h0);
    chk("ar_set", 32'(set_a), 32'h1);
    rst = 1'b0;
    ticks(3);
    chk("ar_hold", 32'(y_a[0]), 32'h1);
    tick();
    chk("ar_flip", 32'(y_a[0]), 32'h0);
    or_a = '0;
    ticks(6);

    // STABLE=1 instance
    and_b[2:0] = 3'b111;
    tick();
    chk("s1_hold", 32'(y_b[0]), 32'h1);
    tick();
    chk("s1_flip", 32'(y_b[0]), 32'h0);
    chk("s1_chg", 32'(ch_b[0]), 32'h1);
    and_b = '0;
    ticks(3);
    or_b[0] = 1'b1;
    tick();
    or_b[0] = 1'b0;
    tick();
    chk("s1_gl", 32'(y_b[0]), 32'h0);
    tick();
    chk("s1_gl_back", 32'(y_b[0]), 32'h1);
    ticks(2);

    // random stimulus
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) begin
        and_a = 8'($urandom);
        or_a  = 8'($urandom) & 8'($urandom) & 8'($urandom);
        and_b = 6'($urandom) | 6'($urandom);
        or_b  = 2'($urandom) & 2'($urandom);
      end
      en = ($urandom_range(9) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
